// File: rtl/fpga_mmio_pkg.sv
// rtl/fpga_mmio_pkg.sv - shared types, default addresses and STATUS layout for the MMIO responder
package fpga_mmio_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    READY = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } mmio_state_t;

  localparam logic [31:0] DEF_NUM1_ADDR = 32'd220;
  localparam logic [31:0] DEF_NUM2_ADDR = 32'd240;
  localparam logic [31:0] DEF_OP_ADDR   = 32'd260;
  localparam logic [31:0] DEF_RES_ADDR  = 32'd280;
  localparam logic [31:0] DEF_STAT_ADDR = 32'd300;

  // one-hot register select bit positions; the low three double as loaded-mask bits
  localparam int SEL_NUM1 = 0;
  localparam int SEL_NUM2 = 1;
  localparam int SEL_OP   = 2;
  localparam int SEL_RES  = 3;
  localparam int SEL_STAT = 4;
  localparam int NUM_SEL  = 5;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_MASK_LSB  = 2;
  localparam int STAT_ERR_LSB   = 8;

  function automatic logic [31:0] pack_status(input mmio_state_t st, input logic [2:0] mask,
                                              input logic [7:0] err);
    logic [31:0] s;
    s = '0;
    s[STAT_STATE_LSB +: 2] = st;
    s[STAT_MASK_LSB  +: 3] = mask;
    s[STAT_ERR_LSB   +: 8] = err;
    return s;
  endfunction

  // AND-OR mux over a one-hot select; an all-zero select yields 0
  function automatic logic [31:0] reg_mux(input logic [NUM_SEL-1:0] sel,
                                          input logic [31:0] n1, input logic [31:0] n2,
                                          input logic [31:0] op, input logic [31:0] res,
                                          input logic [31:0] stat);
    return ({32{sel[SEL_NUM1]}} & n1) | ({32{sel[SEL_NUM2]}} & n2) |
           ({32{sel[SEL_OP]}}   & op) | ({32{sel[SEL_RES]}}  & res) |
           ({32{sel[SEL_STAT]}} & stat);
  endfunction

endpackage

// File: rtl/fpga_mmio_responder_decode.sv
// rtl/fpga_mmio_responder_decode.sv - exact 32-bit address compare to one-hot register select
module mmio_addr_decode
  import fpga_mmio_pkg::*;
#(
  parameter logic [31:0] NUM1_ADDR = DEF_NUM1_ADDR,
  parameter logic [31:0] NUM2_ADDR = DEF_NUM2_ADDR,
  parameter logic [31:0] OP_ADDR   = DEF_OP_ADDR,
  parameter logic [31:0] RES_ADDR  = DEF_RES_ADDR,
  parameter logic [31:0] STAT_ADDR = DEF_STAT_ADDR
) (
  input  logic [31:0]        addr,
  output logic [NUM_SEL-1:0] sel,
  output logic               hit
);

  // full-width compare, so no aliasing of partial address matches
  always_comb begin
    sel           = '0;
    sel[SEL_NUM1] = (addr == NUM1_ADDR);
    sel[SEL_NUM2] = (addr == NUM2_ADDR);
    sel[SEL_OP]   = (addr == OP_ADDR);
    sel[SEL_RES]  = (addr == RES_ADDR);
    sel[SEL_STAT] = (addr == STAT_ADDR);
    hit           = |sel;
  end

endmodule

// File: rtl/fpga_mmio_responder.sv
// rtl/fpga_mmio_responder.sv - FPGA/CPU MMIO hand-off responder; optional FPGA_MMIO_ERRCNT_EN ignored-write counter
module fpga_mmio_responder
  import fpga_mmio_pkg::*;
#(
  parameter logic [31:0] NUM1_ADDR = DEF_NUM1_ADDR,
  parameter logic [31:0] NUM2_ADDR = DEF_NUM2_ADDR,
  parameter logic [31:0] OP_ADDR   = DEF_OP_ADDR,
  parameter logic [31:0] RES_ADDR  = DEF_RES_ADDR,
  parameter logic [31:0] STAT_ADDR = DEF_STAT_ADDR
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        fpga_en,
  input  logic        fpga_write,
  input  logic [31:0] fpga_addr,
  input  logic [31:0] fpga_wdata,
  input  logic        nrstFPGA,
  output logic [31:0] fpga_rdata,
  input  logic        cpu_en,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        done
);

  mmio_state_t        state, state_nxt;
  logic [2:0]         mask;
  logic [31:0]        num1, num2, op_r, result;
  logic [31:0]        status;
  logic [7:0]         errcnt;
  logic [NUM_SEL-1:0] f_sel, c_sel;
  logic               f_hit, c_hit;
  logic               fpga_wr, fpga_wr_ok, cpu_acc, cpu_wr_ok, cpu_claim;

  mmio_addr_decode #(
    .NUM1_ADDR(NUM1_ADDR), .NUM2_ADDR(NUM2_ADDR), .OP_ADDR(OP_ADDR),
    .RES_ADDR(RES_ADDR), .STAT_ADDR(STAT_ADDR)
  ) u_fpga_dec (
    .addr(fpga_addr), .sel(f_sel), .hit(f_hit)
  );

  mmio_addr_decode #(
    .NUM1_ADDR(NUM1_ADDR), .NUM2_ADDR(NUM2_ADDR), .OP_ADDR(OP_ADDR),
    .RES_ADDR(RES_ADDR), .STAT_ADDR(STAT_ADDR)
  ) u_cpu_dec (
    .addr(cpu_addr), .sel(c_sel), .hit(c_hit)
  );

  assign status = pack_status(state, mask, errcnt);

  // FPGA owns the bus on a write; the CPU simply holds its request until released
  assign fpga_wr    = fpga_en && fpga_write;
  assign fpga_wr_ok = fpga_wr && nrstFPGA && ((state == EMPTY) || (state == READY)) &&
                      (|f_sel[SEL_OP:SEL_NUM1]);
  assign cpu_acc    = cpu_en && !fpga_wr;
  assign cpu_wr_ok  = cpu_acc && cpu_write && nrstFPGA && c_sel[SEL_RES] && (state == BUSY);
  assign cpu_claim  = cpu_acc && !cpu_write && c_sel[SEL_STAT] && (state == READY);

  // zero-latency FPGA readback of any register
  always_comb begin
    fpga_rdata = f_hit ? reg_mux(f_sel, num1, num2, op_r, result, status) : 32'd0;
  end

  // hand-off sequencing; the FPGA-side clear overrides every other transition
  always_comb begin
    state_nxt = state;
    if (!nrstFPGA) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (mask == 3'b111) state_nxt = READY;
        READY:   if (cpu_claim)      state_nxt = BUSY;
        BUSY:    if (cpu_wr_ok)      state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // state, loaded mask, data registers and the registered done flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= EMPTY;
      mask   <= '0;
      num1   <= '0;
      num2   <= '0;
      op_r   <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == DONE);
      if (!nrstFPGA)       mask <= '0;
      else if (fpga_wr_ok) mask <= mask | f_sel[SEL_OP:SEL_NUM1];
      if (fpga_wr_ok) begin
        if (f_sel[SEL_NUM1]) num1 <= fpga_wdata;
        if (f_sel[SEL_NUM2]) num2 <= fpga_wdata;
        if (f_sel[SEL_OP])   op_r <= fpga_wdata;
      end
      if (!nrstFPGA && (state == DONE)) result <= '0;
      else if (cpu_wr_ok)               result <= cpu_wdata;
    end
  end

  // CPU response: one-cycle ack, read data captured at acceptance, writes return 0
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack   <= cpu_acc;
      cpu_rdata <= (cpu_acc && !cpu_write && c_hit) ?
                   reg_mux(c_sel, num1, num2, op_r, result, status) : 32'd0;
    end
  end

`ifdef FPGA_MMIO_ERRCNT_EN
  logic ign_any;
  assign ign_any = (fpga_wr && !fpga_wr_ok) || (cpu_acc && cpu_write && !cpu_wr_ok);

  // saturating count of cycles holding at least one dropped write
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                             errcnt <= '0;
    else if (ign_any && (errcnt != 8'hFF)) errcnt <= errcnt + 8'd1;
  end
`else
  assign errcnt = 8'd0;
`endif

endmodule

// File: doc/fpga_mmio_responder.md
Name: fpga_mmio_responder

Overview:
- Memory-mapped responder that receives the FPGA keypad front end's operand/opcode writes and serves the CPU core's reads.
- Holds NUM1, NUM2, OP and RESULT registers, plus a STATUS register. Sequences the hand-off: FPGA loads operands, CPU claims, CPU computes and writes RESULT, FPGA reads RESULT back.
- Sits between the FPGA front end's address/data/enable lines and the CPU data-memory port.

Parameters:
- NUM1_ADDR, 32'd220, NUM1 register address
- NUM2_ADDR, 32'd240, NUM2 register address
- OP_ADDR, 32'd260, opcode register address
- RES_ADDR, 32'd280, RESULT register address
- STAT_ADDR, 32'd300, STATUS register address (read-only)

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- fpga_en  in  1  FPGA access request
- fpga_write  in  1  1=write, 0=read
- fpga_addr  in  32  FPGA byte address
- fpga_wdata  in  32  FPGA write data
- nrstFPGA  in  1  active-low synchronous clear from the FPGA side (DISPLAY exit)
- fpga_rdata  out  32  FPGA read data (combinational from registers)
- cpu_en  in  1  CPU access request
- cpu_write  in  1  1=write, 0=read
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle access acknowledge
- done  out  1  high in DONE state; drives the front end's completion instruction (0xffffffff)

Behaviour:
- Reset (nrst low, async): all data registers 0, state EMPTY, cpu_ack 0, cpu_rdata 0, done 0.
- States:
  - EMPTY: waiting for operands.
  - READY: NUM1, NUM2 and OP each written at least once since the last clear. Tracked by a 3-bit loaded mask.
  - BUSY: CPU claimed the job.
  - DONE: RESULT written.
- Transitions:
  - EMPTY->READY: the cycle after the mask becomes 3'b111.
  - READY->BUSY: accepted CPU read of STAT_ADDR while in READY.
  - BUSY->DONE: accepted CPU write to RES_ADDR.
  - DONE->EMPTY: nrstFPGA low. This clears the mask and RESULT; NUM1/NUM2/OP are retained.
- nrstFPGA low in any other state: forces EMPTY and clears the mask.
- FPGA writes:
  - Accepted only in EMPTY/READY to NUM1/NUM2/OP.
  - Rewriting a register in READY keeps READY.
  - Writes in BUSY/DONE, or to RES_ADDR/STAT_ADDR, are ignored.
- FPGA reads: combinational, zero latency. Any register is readable. Unmapped addresses read 0.
- CPU accesses:
  - Accepted when cpu_en is high and there is no FPGA write conflict.
  - cpu_ack is registered, 1 cycle after acceptance. cpu_rdata is registered and valid in the same cycle as cpu_ack.
  - CPU writes allowed only to RES_ADDR in BUSY. Any other CPU write is acked and ignored.
- Conflict: if fpga_en && fpga_write && cpu_en occur in the same cycle, the FPGA wins. The CPU access is not accepted and cpu_ack stays 0; the CPU holds its request.
- STATUS layout:
  - [1:0] state code (EMPTY=0, READY=1, BUSY=2, DONE=3)
  - [4:2] loaded mask
  - [15:8] error count (see Optional Feature)
  - other bits 0
- done = (state==DONE), registered.
- Unmapped addresses: a CPU read returns 0 with ack; a write has no effect. No wrap or aliasing; exact compare on the full 32-bit address.

Optional Feature:
- Macro FPGA_MMIO_ERRCNT_EN.
- Defined: an 8-bit saturating counter of ignored writes from either side. It increments by 1 per cycle containing any ignored write (2 ignored writes in the same cycle still add 1). It saturates at 255, is cleared only by nrst, and is visible at STATUS[15:8].
- Undefined: STATUS[15:8] reads 0 and no counter logic is present.

Decomposition:
- Package fpga_mmio_pkg: state enum mmio_state_t {EMPTY, READY, BUSY, DONE}, the default address constants, and STATUS bit-position constants.
- One sub-module, mmio_addr_decode: maps an address to a one-hot register select plus a hit flag. Instantiated twice, once per port.

Test Plan:
- Reset with nrst low mid-BUSY -> state EMPTY, all registers 0, done 0, cpu_ack 0 on the next edge without clk.
- FPGA writes 0x12 @220, 0x05 @260, 0x34 @240 -> STATUS reads 0x1D (READY, mask 111). CPU read @300 -> cpu_ack 1 cycle later with cpu_rdata 0x1D, state BUSY.
- In BUSY: CPU writes 0x46 @280 -> done=1 next cycle, fpga_rdata@280 = 0x46. Then nrstFPGA low 1 cycle -> EMPTY, RESULT 0, NUM1 still 0x12.
- Same-cycle FPGA write @220 and CPU read @300 -> NUM1 updated, no cpu_ack that cycle. CPU held -> ack 1 cycle after the FPGA releases.
- In BUSY: FPGA write 0x99 @220 -> NUM1 unchanged. With FPGA_MMIO_ERRCNT_EN defined, STATUS[15:8]=1; after 300 ignored writes, STATUS[15:8]=255.
- CPU read @0x400 (unmapped) -> cpu_ack with cpu_rdata 0, state unchanged.
